// File: rtl/apb_master_wait_bridge.sv
// Purpose : single-outstanding APB master; one valid/ready command becomes one SETUP/ACCESS transfer.
// Latency : accept at edge N -> SETUP N+1, ACCESS N+2, rsp_valid N+3, cmd_ready N+4; +1 per PREADY-low cycle.
// Backpr. : cmd_ready only in IDLE, no queueing; slave wait states stall until PREADY or the wait-state timeout.
//
// Ports:
//   PCLK, PRESETn                      clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write/addr/wdata/strb          command payload
//   rsp_valid                          one-cycle response pulse
//   rsp_rdata/rsp_err/rsp_timeout      response payload, held until the next response
//   PSEL/PENABLE/PADDR/PWRITE/PSTRB/PWDATA   APB request towards the slave
//   PRDATA/PREADY/PSLVERR              APB completion from the slave
module apb_master_wait_bridge #(
   parameter int PADDR_SIZE = 4,
   parameter int PDATA_SIZE = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,

   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [PADDR_SIZE-1:0]     cmd_addr,
   input  logic [PDATA_SIZE-1:0]     cmd_wdata,
   input  logic [PDATA_SIZE/8-1:0]   cmd_strb,

   output logic                      rsp_valid,
   output logic [PDATA_SIZE-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,

   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [PADDR_SIZE-1:0]     PADDR,
   output logic [PDATA_SIZE/8-1:0]   PSTRB,
   output logic [PDATA_SIZE-1:0]     PWDATA,
   input  logic [PDATA_SIZE-1:0]     PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   // The counter only needs to reach TIMEOUT-1; a disabled timeout keeps a 1-bit dummy.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TO_EN = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             access_done;

   // Gated by PRESETn so the port reads 0 while reset is held, 1 in IDLE afterwards.
   assign cmd_ready = PRESETn && (state == IDLE);

   // A slave answering on the last permitted wait cycle completes normally,
   // so the timeout only fires while PREADY is still low.
   always_comb begin
      timeout_hit = 1'b0;
      if (TO_EN && (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST))
         timeout_hit = 1'b1;
   end

   assign access_done = (state == ACCESS) && (PREADY || timeout_hit);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PSTRB       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state    <= SETUP;
                  wait_cnt <= '0;
                  PSEL     <= 1'b1;
                  PENABLE  <= 1'b0;
                  PWRITE   <= cmd_write;
                  PADDR    <= cmd_addr;
                  // Reads carry no strobes and no write data on the bus.
                  PSTRB    <= cmd_write ? cmd_strb  : '0;
                  PWDATA   <= cmd_write ? cmd_wdata : '0;
               end
            end

            SETUP: begin
               state   <= ACCESS;
               PENABLE <= 1'b1;
            end

            ACCESS: begin
               if (access_done) begin
                  state       <= RESP;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  PWRITE      <= 1'b0;
                  PADDR       <= '0;
                  PSTRB       <= '0;
                  PWDATA      <= '0;
                  rsp_valid   <= 1'b1;
                  // PRDATA/PSLVERR are only meaningful with PREADY high.
                  rsp_rdata   <= (PREADY && !PWRITE) ? PRDATA : '0;
                  rsp_err     <= PREADY ? PSLVERR : 1'b1;
                  rsp_timeout <= !PREADY;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end

            RESP: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_wait_bridge.sv
module tb_apb_master_wait_bridge;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [3:0]  PADDR;
   logic [3:0]  PSTRB;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int errors = 0;
   int checks = 0;

   apb_master_wait_bridge #(
      .PADDR_SIZE (4),
      .PDATA_SIZE (32),
      .TIMEOUT    (4)
   ) dut (
      .PCLK        (PCLK),
      .PRESETn     (PRESETn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PSTRB       (PSTRB),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; everything is driven and sampled 1 time unit later.
   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Present a command for exactly one edge (the accepting edge N).
   task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_strb  = s;
      tick();
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
   endtask

   initial begin
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_strb  = '0;
      PRDATA    = '0;
      PREADY    = 1'b1;
      PSLVERR   = 1'b0;

      // ---------------- reset state
      tick();
      chk("rst_psel",      32'(PSEL), 32'd0);
      chk("rst_penable",   32'(PENABLE), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      PRESETn = 1'b1;
      tick();
      chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // ---------------- zero-wait write
      issue(1'b1, 4'h1, 32'h0000_00FF, 4'hF);
      chk("wr_setup_psel",    32'(PSEL), 32'd1);
      chk("wr_setup_penable", 32'(PENABLE), 32'd0);
      chk("wr_setup_pwrite",  32'(PWRITE), 32'd1);
      chk("wr_setup_pstrb",   32'(PSTRB), 32'hF);
      chk("wr_setup_paddr",   32'(PADDR), 32'h1);
      chk("wr_setup_pwdata",  PWDATA, 32'h0000_00FF);
      chk("wr_setup_ready",   32'(cmd_ready), 32'd0);
      tick();
      chk("wr_access_psel",    32'(PSEL), 32'd1);
      chk("wr_access_penable", 32'(PENABLE), 32'd1);
      chk("wr_access_rsp",     32'(rsp_valid), 32'd0);
      tick();
      chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("wr_rsp_err",   32'(rsp_err), 32'd0);
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      chk("wr_rsp_psel",  32'(PSEL), 32'd0);
      chk("wr_rsp_ready", 32'(cmd_ready), 32'd0);
      tick();
      chk("wr_done_valid", 32'(rsp_valid), 32'd0);
      chk("wr_done_ready", 32'(cmd_ready), 32'd1);

      // ---------------- read with 3 wait states (garbage PRDATA while waiting)
      PREADY = 1'b0;
      PRDATA = 32'hDEAD_BEEF;
      issue(1'b0, 4'h3, 32'h1111_2222, 4'hF);
      chk("rd_setup_pstrb",  32'(PSTRB), 32'h0);
      chk("rd_setup_pwrite", 32'(PWRITE), 32'd0);
      chk("rd_setup_paddr",  32'(PADDR), 32'h3);
      tick();
      chk("rd_access_penable", 32'(PENABLE), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rd_wait_paddr",   32'(PADDR), 32'h3);
         chk("rd_wait_pstrb",   32'(PSTRB), 32'h0);
         chk("rd_wait_penable", 32'(PENABLE), 32'd1);
         chk("rd_wait_rsp",     32'(rsp_valid), 32'd0);
      end
      PREADY = 1'b1;
      PRDATA = 32'hA5A5_0001;
      tick();
      chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rd_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      chk("rd_rsp_err",   32'(rsp_err), 32'd0);
      tick();
      chk("rd_done_ready", 32'(cmd_ready), 32'd1);

      // ---------------- slave error, zero wait
      PREADY  = 1'b1;
      PSLVERR = 1'b1;
      issue(1'b1, 4'h0, 32'h0000_0055, 4'h1);
      tick();
      tick();
      chk("err_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("err_rsp_err",     32'(rsp_err), 32'd1);
      chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
      PSLVERR = 1'b0;
      tick();

      // ---------------- PSLVERR during a wait state is ignored
      PREADY  = 1'b0;
      PSLVERR = 1'b1;
      issue(1'b1, 4'h2, 32'h0000_0066, 4'h3);
      tick();
      tick();
      chk("errign_wait_rsp", 32'(rsp_valid), 32'd0);
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      tick();
      chk("errign_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("errign_rsp_err",   32'(rsp_err), 32'd0);
      tick();

      // ---------------- timeout: PREADY held low, abort after 4 ACCESS cycles
      PREADY = 1'b0;
      PRDATA = 32'hFFFF_FFFF;
      issue(1'b0, 4'h2, 32'h0, 4'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("to_wait_rsp",  32'(rsp_valid), 32'd0);
         chk("to_wait_psel", 32'(PSEL), 32'd1);
      end
      tick();
      chk("to_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("to_rsp_err",     32'(rsp_err), 32'd1);
      chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
      chk("to_rsp_rdata",   rsp_rdata, 32'd0);
      chk("to_rsp_psel",    32'(PSEL), 32'd0);
      chk("to_rsp_penable", 32'(PENABLE), 32'd0);
      tick();
      chk("to_done_valid",   32'(rsp_valid), 32'd0);
      chk("to_hold_timeout", 32'(rsp_timeout), 32'd1);
      chk("to_done_ready",   32'(cmd_ready), 32'd1);

      // ---------------- timeout race: PREADY rises on the 4th ACCESS cycle
      PREADY = 1'b0;
      issue(1'b0, 4'h3, 32'h0, 4'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("race_wait_rsp", 32'(rsp_valid), 32'd0);
      end
      PREADY = 1'b1;
      PRDATA = 32'h0000_1234;
      tick();
      chk("race_rsp_valid",   32'(rsp_valid), 32'd1);
      chk("race_rsp_timeout", 32'(rsp_timeout), 32'd0);
      chk("race_rsp_err",     32'(rsp_err), 32'd0);
      chk("race_rsp_rdata",   rsp_rdata, 32'h0000_1234);
      tick();

      // ---------------- reset asserted during ACCESS
      PREADY = 1'b0;
      issue(1'b0, 4'h1, 32'h0, 4'h0);
      tick();
      tick();
      chk("mrst_pre_penable", 32'(PENABLE), 32'd1);
      PRESETn = 1'b0;
      #1;
      chk("mrst_async_psel",    32'(PSEL), 32'd0);
      chk("mrst_async_penable", 32'(PENABLE), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("mrst_hold_rsp", 32'(rsp_valid), 32'd0);
      end
      PRESETn = 1'b1;
      PREADY  = 1'b1;
      tick();
      chk("mrst_after_ready", 32'(cmd_ready), 32'd1);
      chk("mrst_after_rsp",   32'(rsp_valid), 32'd0);
      PRDATA = 32'hCAFE_0002;
      issue(1'b0, 4'h2, 32'h0, 4'h0);
      chk("mrst_new_paddr", 32'(PADDR), 32'h2);
      tick();
      chk("mrst_new_rsp_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("mrst_new_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("mrst_new_rsp_rdata", rsp_rdata, 32'hCAFE_0002);
      chk("mrst_new_rsp_err",   32'(rsp_err), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/apb_master_wait_bridge.md
Name: apb_master_wait_bridge

Overview:
- Single-outstanding APB master bridge that turns a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Sits directly upstream of the GPIO slave and drives its PSEL/PENABLE/PADDR/PWRITE/PSTRB/PWDATA.
- Honours slave wait states (PREADY low), captures PRDATA/PSLVERR and aborts hung transfers via a wait-state timeout.
- Returns one response per command.

Parameters:
- PADDR_SIZE, 4, APB address width.
- PDATA_SIZE, 32, APB data width; multiple of 8.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 = timeout disabled.

Ports:
- PCLK  in  1  APB clock, all logic on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  PADDR_SIZE  target address.
- cmd_wdata  in  PDATA_SIZE  write data.
- cmd_strb  in  PDATA_SIZE/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  PDATA_SIZE  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PADDR  out  PADDR_SIZE  APB address.
- PSTRB  out  PDATA_SIZE/8  APB strobes.
- PWDATA  out  PDATA_SIZE  APB write data.
- PRDATA  in  PDATA_SIZE  slave read data.
- PREADY  in  1  slave ready; low = wait state.
- PSLVERR  in  1  slave error, valid only with PREADY.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; wait counter 0.
  - cmd_ready=1 in IDLE once reset is released.
- Registers: all outputs registered except cmd_ready, which is decoded from state (IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch write/addr/wdata/strb, go to SETUP.
  - PSTRB is forced to 0 for reads.
- SETUP: PSEL=1, PENABLE=0, address/control/data driven; next cycle go to ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into rsp_err, rsp_timeout=0, go to RESP.
  - PREADY=0: wait counter +1, stay in ACCESS.
  - Timeout: if TIMEOUT!=0, counter==TIMEOUT-1 and PREADY=0, abort. rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - PREADY=1 in the same cycle as the timeout limit: normal completion wins.
- RESP:
  - PSEL=PENABLE=0, rsp_valid=1 for exactly one cycle, wait counter cleared, return to IDLE.
  - rsp_rdata/rsp_err/rsp_timeout hold until the next response.
- Signal stability: PADDR, PWRITE, PSTRB and PWDATA stay constant from SETUP through the last ACCESS cycle. They return to 0 in IDLE/RESP.
- Zero-wait latency:
  - Command accepted at edge N.
  - SETUP in cycle N+1.
  - ACCESS in N+2.
  - rsp_valid in N+3.
  - cmd_ready again in N+4.
  - Each PREADY-low cycle adds 1.
- Sampling: PSLVERR and PRDATA are ignored while PREADY=0.
- Commands presented while not in IDLE are not accepted (cmd_ready=0); no queueing.
- Reset asserted mid-transfer:
  - Immediately drop PSEL/PENABLE and the pending response.
  - No rsp_valid is generated for the aborted command.

Test Plan:
- Zero-wait write: cmd addr=0x1, wdata=0x0000_00FF, strb=0xF, slave PREADY tied 1.
  - Required: PSEL rises at N+1, PENABLE at N+2, PWRITE=1, PSTRB=0xF.
  - Required: rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x3, PREADY low for 3 ACCESS cycles, then high with PRDATA=0xA5A5_0001.
  - Required: PSTRB=0, PADDR stable throughout.
  - Required: rsp_valid at N+6, rsp_rdata=0xA5A5_0001.
- Slave error: write addr=0x0 with PREADY=1, PSLVERR=1.
  - Required: rsp_err=1, rsp_timeout=0.
  - Required: PSLVERR=1 driven while PREADY=0 beforehand is ignored.
- Timeout: TIMEOUT=4, PREADY held 0.
  - Required: abort after 4 ACCESS cycles; rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Required: PSEL=0 in RESP.
- Timeout race: TIMEOUT=4, PREADY rises exactly on the 4th ACCESS cycle with PRDATA=0x1234.
  - Required: normal completion, rsp_timeout=0, rsp_rdata=0x1234.
- Reset mid-transfer: assert PRESETn=0 during ACCESS (PREADY=0).
  - Required: PSEL/PENABLE=0 asynchronously, no rsp_valid.
  - Required: after release, cmd_ready=1 and a new read completes normally.
